capture_fifo_sc: RTL and testbench

- Single-clock, parametrised capture FIFO for frontends that run in the USB clock domain; the successor to the dual-clock Xilinx-IP capture FIFO.
- Implemented in inferred RAM, so no generator core is needed. Width, depth and mode are set by parameters or registers.
- Adds runtime-programmable full/empty thresholds, an exact occupancy count, and a circular overwrite mode for pre-trigger capture.
- Sits between fe_capture_<frontend> (write side) and reg_main (read side); its status vector keeps the existing FIFO_STAT_* bit layout.

---
 rtl/capture_fifo_sc_pkg.sv | 33 +++
 rtl/capture_fifo_ram.sv | 48 ++++
 rtl/capture_fifo_sc.sv | 138 +++++++++++++
 tb/tb_capture_fifo_sc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_fifo_sc_pkg.sv
// Shared constants for the single-clock capture FIFO: status-vector bit layout and mode decode.
package capture_fifo_sc_pkg;

    localparam int FIFO_STAT_EMPTY            = 0;
    localparam int FIFO_STAT_UNDERFLOW        = 1;
    localparam int FIFO_STAT_EMPTY_THRESHOLD  = 2;
    localparam int FIFO_STAT_FULL             = 3;
    localparam int FIFO_STAT_OVERFLOW_BLOCKED = 4;
    localparam int FIFO_STAT_CUSTOM_FLAG      = 5;
    localparam int FIFO_STAT_W                = 6;

    localparam logic FIFO_MODE_OVERWRITE = 1'b1;

    function automatic logic [FIFO_STAT_W-1:0] fifo_status(
        input logic empty,
        input logic underflow,
        input logic empty_thresh,
        input logic full,
        input logic overflow,
        input logic custom
    );
        logic [FIFO_STAT_W-1:0] s;
        s                             = '0;
        s[FIFO_STAT_EMPTY]            = empty;
        s[FIFO_STAT_UNDERFLOW]        = underflow;
        s[FIFO_STAT_EMPTY_THRESHOLD]  = empty_thresh;
        s[FIFO_STAT_FULL]             = full;
        s[FIFO_STAT_OVERFLOW_BLOCKED] = overflow;
        s[FIFO_STAT_CUSTOM_FLAG]      = custom;
        return s;
    endfunction

endpackage

// File: rtl/capture_fifo_ram.sv
// Simple dual-port storage: one write port, one read port with a registered, enable-held output.
// Read-before-write on an address collision, so a read of the oldest entry survives an overwrite.
module capture_fifo_ram #(
    parameter int    DATA_W    = 18,
    parameter int    ADDR_W    = 13,
    parameter string RAM_STYLE = "block"
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] rd_q;

    generate
        if (RAM_STYLE == "distributed") begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

            always_ff @(posedge clk_i) begin
                if (wr_en_i) mem[wr_addr_i] <= wr_dat_i;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)        rd_q <= '0;
                else if (rd_en_i) rd_q <= mem[rd_addr_i];
            end
        end else begin : g_block
            (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

            always_ff @(posedge clk_i) begin
                if (wr_en_i) mem[wr_addr_i] <= wr_dat_i;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)        rd_q <= '0;
                else if (rd_en_i) rd_q <= mem[rd_addr_i];
            end
        end
    endgenerate

    assign rd_dat_o = rd_q;

endmodule

// File: rtl/capture_fifo_sc.sv
// Single-clock capture FIFO with exact count, programmable thresholds and optional overwrite-oldest mode.
// Read data one cycle after an accepted read; writes are refused when full unless overwrite mode is on.
module capture_fifo_sc
    import capture_fifo_sc_pkg::*;
#(
    parameter int    DATA_W     = 18,
    parameter int    DEPTH_LOG2 = 13,
    parameter string RAM_STYLE  = "block"
) (
    input  logic                  cwusb_clk,
    input  logic                  reset_i,
    input  logic [DATA_W-1:0]     I_data,
    input  logic                  I_wr,
    input  logic                  I_fifo_read,
    input  logic                  I_fifo_flush,
    input  logic                  I_overwrite_mode,
    input  logic [DEPTH_LOG2:0]   I_full_thresh,
    input  logic [DEPTH_LOG2:0]   I_empty_thresh,
    input  logic                  I_clear_errors,
    input  logic                  I_custom_fifo_stat_flag,
    output logic [DATA_W-1:0]     O_data,
    output logic                  O_data_valid,
    output logic [DEPTH_LOG2:0]   O_count,
    output logic                  O_fifo_full,
    output logic                  O_fifo_empty,
    output logic                  O_prog_full,
    output logic                  O_fifo_overflow_blocked,
    output logic                  O_overwrote,
    output logic [FIFO_STAT_W-1:0] O_fifo_status,
    output logic                  O_error_flag
);

    localparam int               CW        = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]    DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, valid_q;
    logic                  underflow_q, blocked_q, overwrote_q;

    logic wr_ok, rd_ok, discard, underflow_ev, blocked_ev, overwrite, inc, dec;
    logic empty_thresh;

    assign overwrite = (I_overwrite_mode == FIFO_MODE_OVERWRITE);

    // Full/empty are judged on the pre-edge state; a same-cycle read never makes room for a blocked write.
    always_comb begin
        wr_ok        = 1'b0;
        rd_ok        = 1'b0;
        discard      = 1'b0;
        underflow_ev = 1'b0;
        blocked_ev   = 1'b0;
        if (!I_fifo_flush) begin
            rd_ok        = I_fifo_read & ~empty_q;
            underflow_ev = I_fifo_read &  empty_q;
            if (I_wr) begin
                if (!full_q) begin
                    wr_ok = 1'b1;
                end else if (overwrite) begin
                    wr_ok   = 1'b1;
                    discard = ~rd_ok;
                end else begin
                    blocked_ev = 1'b1;
                end
            end
        end
    end

    assign inc = wr_ok & ~discard;
    assign dec = rd_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_ok);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_ok | discard);
        count_d  = count_q;
        if (inc && !dec)      count_d = count_q + CW'(1);
        else if (dec && !inc) count_d = count_q - CW'(1);
        if (I_fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
            blocked_q   <= 1'b0;
            overwrote_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_CNT);
            empty_q     <= (count_d == '0);
            valid_q     <= rd_ok;
            underflow_q <= underflow_ev | (underflow_q & ~I_clear_errors);
            blocked_q   <= blocked_ev   | (blocked_q   & ~I_clear_errors);
            overwrote_q <= discard      | (overwrote_q & ~I_clear_errors);
        end
    end

    capture_fifo_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (DEPTH_LOG2),
        .RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .clk_i     (cwusb_clk),
        .rst_i     (reset_i),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (I_data),
        .rd_en_i   (rd_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (O_data)
    );

    // Compared against the count register so a new threshold applies at once and follows it through reset.
    assign O_prog_full  = (count_q >= I_full_thresh);
    assign empty_thresh = (count_q <= I_empty_thresh) & ~empty_q;

    assign O_data_valid            = valid_q;
    assign O_count                 = count_q;
    assign O_fifo_full             = full_q;
    assign O_fifo_empty            = empty_q;
    assign O_fifo_overflow_blocked = blocked_q;
    assign O_overwrote             = overwrote_q;
    assign O_error_flag            = underflow_q | blocked_q;
    assign O_fifo_status           = fifo_status(empty_q, underflow_q, empty_thresh, full_q,
                                                 blocked_q | overwrote_q, I_custom_fifo_stat_flag);

endmodule

// File: tb/tb_capture_fifo_sc.sv
// Bench for capture_fifo_sc at DEPTH=8: directed table, corner sequences and random traffic against a queue model.
module tb_capture_fifo_sc;

    localparam int DW = 18;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int CW = AW + 1;

    localparam int ST_EMPTY = 0, ST_UNDER = 1, ST_ETHR = 2, ST_FULL = 3, ST_OVF = 4, ST_CUST = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] din;
    logic          wr, rd, flush, ovw, clr, cust;
    logic [CW-1:0] fth, eth;

    logic [DW-1:0] O_data;
    logic          O_data_valid, O_fifo_full, O_fifo_empty, O_prog_full;
    logic          O_fifo_overflow_blocked, O_overwrote, O_error_flag;
    logic [CW-1:0] O_count;
    logic [5:0]    O_fifo_status;

    capture_fifo_sc #(.DATA_W(DW), .DEPTH_LOG2(AW), .RAM_STYLE("block")) dut (
        .cwusb_clk               (clk),
        .reset_i                 (rst),
        .I_data                  (din),
        .I_wr                    (wr),
        .I_fifo_read             (rd),
        .I_fifo_flush            (flush),
        .I_overwrite_mode        (ovw),
        .I_full_thresh           (fth),
        .I_empty_thresh          (eth),
        .I_clear_errors          (clr),
        .I_custom_fifo_stat_flag (cust),
        .O_data                  (O_data),
        .O_data_valid            (O_data_valid),
        .O_count                 (O_count),
        .O_fifo_full             (O_fifo_full),
        .O_fifo_empty            (O_fifo_empty),
        .O_prog_full             (O_prog_full),
        .O_fifo_overflow_blocked (O_fifo_overflow_blocked),
        .O_overwrote             (O_overwrote),
        .O_fifo_status           (O_fifo_status),
        .O_error_flag            (O_error_flag)
    );

    // Reference model: contents as a queue plus sticky flags and the last read word.
    logic [DW-1:0] mq[$];
    bit            m_und, m_blk, m_ovr, m_vld;
    logic [DW-1:0] m_dat;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            wr, rd, ovw, clr;
        logic [DW-1:0] din;
        int            exp_cnt;
        bit            exp_vld;
        logic [DW-1:0] exp_dat;
        bit            exp_blk, exp_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_und = 0; m_blk = 0; m_ovr = 0; m_vld = 0;
        m_dat = '0;
    endtask

    task automatic model_edge();
        int n = mq.size();
        bit ue = 0, be = 0, oe = 0;
        m_vld = 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (rd && n > 0) begin
                m_dat = mq.pop_front();
                m_vld = 1;
            end else if (rd) begin
                ue = 1;
            end
            if (wr) begin
                if (n < DEPTH) mq.push_back(din);
                else if (ovw) begin
                    if (!m_vld) begin
                        void'(mq.pop_front());
                        oe = 1;
                    end
                    mq.push_back(din);
                end else be = 1;
            end
        end
        m_und = ue | (m_und & !clr);
        m_blk = be | (m_blk & !clr);
        m_ovr = oe | (m_ovr & !clr);
    endtask

    task automatic check_all();
        int n = mq.size();
        bit e = (n == 0);
        bit f = (n == DEPTH);
        bit pf = (n >= int'(fth));
        bit et = (n <= int'(eth)) && !e;
        logic [5:0] st;
        st = '0;
        st[ST_EMPTY] = e;
        st[ST_UNDER] = m_und;
        st[ST_ETHR]  = et;
        st[ST_FULL]  = f;
        st[ST_OVF]   = m_blk | m_ovr;
        st[ST_CUST]  = cust;
        chk("count", 32'(O_count), 32'(n));
        chk("data_valid", 32'(O_data_valid), 32'(m_vld));
        chk("data", 32'(O_data), 32'(m_dat));
        chk("flags{full,empty,pfull,blk,ovr,err}",
            32'({O_fifo_full, O_fifo_empty, O_prog_full, O_fifo_overflow_blocked, O_overwrote, O_error_flag}),
            32'({f, e, pf, m_blk, m_ovr, m_und | m_blk}));
        chk("status", 32'(O_fifo_status), 32'(st));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        wr = 0; rd = 0; flush = 0; clr = 0;
    endtask

    function automatic vec_t mk(bit w, bit r, bit o, bit c, int d, int cnt, bit v, int dat, bit b, bit ov);
        vec_t t;
        t.wr = w; t.rd = r; t.ovw = o; t.clr = c;
        t.din = DW'(d); t.exp_cnt = cnt; t.exp_vld = v; t.exp_dat = DW'(dat);
        t.exp_blk = b; t.exp_ovr = ov;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: fill/drain, blocked overflow, clear, overwrite fill/drain, clear.
        for (int i = 0; i < 8; i++)  tbl.push_back(mk(1, 0, 0, 0, i, i + 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 'h3FFFF, 8, 0, 0, 1, 0));
        for (int i = 0; i < 8; i++)  tbl.push_back(mk(0, 1, 0, 0, 0, 7 - i, 1, i, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++) tbl.push_back(mk(1, 0, 1, 0, i, (i < 8) ? i + 1 : 8, 0, 0, 0, i >= 8));
        for (int i = 0; i < 8; i++)  tbl.push_back(mk(0, 1, 1, 0, 0, 7 - i, 1, i + 3, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        rst = 1; idle(); ovw = 0; cust = 0; din = '0;
        fth = '0; eth = '0;
        model_reset();
        #3;
        check_all();
        chk("reset_prog_full_thresh0", 32'(O_prog_full), 32'd1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        fth = 4'd9;
        eth = 4'd0;
        #1;
        check_all();

        foreach (tbl[k]) begin
            wr = tbl[k].wr; rd = tbl[k].rd; ovw = tbl[k].ovw; clr = tbl[k].clr; din = tbl[k].din;
            cycle();
            chk("tbl_count", 32'(O_count), 32'(tbl[k].exp_cnt));
            chk("tbl_valid", 32'(O_data_valid), 32'(tbl[k].exp_vld));
            if (tbl[k].exp_vld) chk("tbl_data", 32'(O_data), 32'(tbl[k].exp_dat));
            chk("tbl_blocked", 32'(O_fifo_overflow_blocked), 32'(tbl[k].exp_blk));
            chk("tbl_overwrote", 32'(O_overwrote), 32'(tbl[k].exp_ovr));
            chk("tbl_error", 32'(O_error_flag), 32'(tbl[k].exp_blk));
        end
        idle(); ovw = 0;

        // Underflow on empty.
        rd = 1; cycle(); idle();
        chk("underflow_flag", 32'(O_fifo_status[ST_UNDER]), 32'd1);
        chk("underflow_valid", 32'(O_data_valid), 32'd0);
        chk("underflow_err", 32'(O_error_flag), 32'd1);

        // Read + write while empty: write lands, read is an underflow.
        rd = 1; wr = 1; din = 'h155; cycle(); idle();
        chk("rw_empty_count", 32'(O_count), 32'd1);
        chk("rw_empty_valid", 32'(O_data_valid), 32'd0);

        // Read + write at count 4.
        for (int i = 0; i < 3; i++) begin wr = 1; din = DW'('h200 + i); cycle(); end
        idle();
        rd = 1; wr = 1; din = 'h2AA; cycle(); idle();
        chk("rw_mid_count", 32'(O_count), 32'd4);
        chk("rw_mid_data", 32'(O_data), 32'h155);

        // Flush with a simultaneous write at count 5; sticky underflow survives.
        wr = 1; din = 'h2BB; cycle();
        flush = 1; cycle(); idle();
        chk("flush_count", 32'(O_count), 32'd0);
        chk("flush_keeps_sticky", 32'(O_fifo_status[ST_UNDER]), 32'd1);
        clr = 1; cycle(); idle();
        chk("clear_err", 32'(O_error_flag), 32'd0);

        // Thresholds: full at 6, empty-threshold at 2.
        fth = 4'd6; eth = 4'd2;
        for (int i = 0; i < 6; i++) begin
            wr = 1; din = DW'('h100 + i); cycle();
            chk("prog_full_rise", 32'(O_prog_full), 32'(i >= 5));
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            rd = 1; cycle();
            chk("empty_thresh", 32'(O_fifo_status[ST_ETHR]), 32'((5 - i) <= 2 && (5 - i) > 0));
        end
        idle();

        // Overwrite mode, full, with a simultaneous read: no discard.
        ovw = 1;
        for (int i = 0; i < 8; i++) begin wr = 1; din = DW'('h300 + i); cycle(); end
        rd = 1; wr = 1; din = 'h3AA; cycle(); idle();
        chk("ovw_rw_count", 32'(O_count), 32'd8);
        chk("ovw_rw_data", 32'(O_data), 32'h300);
        chk("ovw_rw_no_discard", 32'(O_overwrote), 32'd0);
        ovw = 0;

        // Async reset in the middle of a burst.
        rd = 1; wr = 1;
        for (int i = 0; i < 3; i++) begin din = DW'($urandom); cycle(); end
        #1;
        rst = 1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_count", 32'(O_count), 32'd0);
        chk("async_rst_empty", 32'(O_fifo_empty), 32'd1);
        idle();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check_all();

        // Random traffic with occasional mode, threshold, flush and clear changes.
        for (int c = 0; c < 3000; c++) begin
            int wbias = ((c / 150) % 2 == 0) ? 65 : 35;
            wr    = ($urandom_range(0, 99) < wbias);
            rd    = ($urandom_range(0, 99) < (100 - wbias));
            flush = ($urandom_range(0, 99) < 2);
            clr   = ($urandom_range(0, 99) < 4);
            cust  = $urandom_range(0, 1) == 1;
            din   = DW'($urandom);
            if ($urandom_range(0, 39) == 0) ovw = ~ovw;
            if ($urandom_range(0, 99) == 0) fth = CW'($urandom_range(0, 9));
            if ($urandom_range(0, 99) == 0) eth = CW'($urandom_range(0, 8));
            cycle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
